// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/write-back sequencer that drives the next-PC
// value and load enable of an external ProgramCounter.
//
// Optional feature: define PC_SEQUENCER_RAS_EN to compile in a 4-entry
// return-address stack used by call/ret. Without it, call behaves as jump,
// ret as increment, and ras_err is tied low.
//
// States (state output code):
//   state | meaning
//   IDLE  | 0, leaving reset, moves to FETCH on the first edge
//   FETCH | 1, imem_req asserted, waiting for imem_ack
//   EXEC  | 2, waiting for exec_done, next PC chosen at that edge
//   WRITE | 3, one cycle with enable=1 while the PC loads `in`
//   HALT  | 4, halted=1, left only by reset
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   pc           current ProgramCounter value
//   in           registered next-PC value to ProgramCounter
//   enable       ProgramCounter load enable (high only in WRITE)
//   imem_req     instruction fetch request
//   imem_ack     instruction memory acknowledge
//   exec_done    current instruction retired
//   branch_taken, jump, call, ret, halt  redirect controls (with exec_done)
//   target       branch/jump/call destination
//   state        FSM state code
//   halted       high in HALT
//   ras_err      sticky return-stack overflow/underflow flag

module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pc,
    output logic [10:0] in,
    output logic        enable,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        call,
    input  logic        ret,
    input  logic        halt,
    input  logic [10:0] target,
    output logic [2:0]  state,
    output logic        halted,
    output logic        ras_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state_q;
    logic [10:0] in_q;
    logic        enable_q;
    logic        imem_req_q;
    logic        halted_q;

    logic [10:0] pc_inc;
    logic [10:0] next_pc_d;

    assign pc_inc = pc + 11'd1;

`ifdef PC_SEQUENCER_RAS_EN
    logic [10:0] ras_q [4];
    logic [2:0]  ras_cnt_q;
    logic        ras_err_q;
    logic        push_d;
    logic        pop_d;
    logic        err_d;
    logic [1:0]  top_idx;

    // Count 4 wraps to 2'b00 in the low bits, so minus one still lands on 3.
    assign top_idx = ras_cnt_q[1:0] - 2'd1;

    always_comb begin
        next_pc_d = pc_inc;
        push_d    = 1'b0;
        pop_d     = 1'b0;
        err_d     = 1'b0;
        if (ret) begin
            if (ras_cnt_q == 3'd0) begin
                err_d = 1'b1;
            end else begin
                pop_d     = 1'b1;
                next_pc_d = ras_q[top_idx];
            end
        end else if (call) begin
            next_pc_d = target;
            push_d    = 1'b1;
            if (ras_cnt_q == 3'd4) begin
                err_d = 1'b1;
            end
        end else if (jump || branch_taken) begin
            next_pc_d = target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_cnt_q <= 3'd0;
            ras_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ras_q[i] <= 11'd0;
            end
        end else if (state_q == EXEC && exec_done && !halt) begin
            if (err_d) begin
                ras_err_q <= 1'b1;
            end
            if (push_d) begin
                if (ras_cnt_q == 3'd4) begin
                    // Full: drop the oldest entry at index 0.
                    for (int i = 0; i < 3; i++) begin
                        ras_q[i] <= ras_q[i+1];
                    end
                    ras_q[3] <= pc_inc;
                end else begin
                    ras_q[ras_cnt_q[1:0]] <= pc_inc;
                    ras_cnt_q <= ras_cnt_q + 3'd1;
                end
            end else if (pop_d) begin
                ras_cnt_q <= ras_cnt_q - 3'd1;
            end
        end
    end

    assign ras_err = ras_err_q;
`else
    // ret is still honoured in the priority order; it just selects increment.
    always_comb begin
        next_pc_d = pc_inc;
        if (ret) begin
            next_pc_d = pc_inc;
        end else if (call || jump || branch_taken) begin
            next_pc_d = target;
        end
    end

    assign ras_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            in_q       <= 11'd0;
            enable_q   <= 1'b0;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Request rises one edge later so the first fetch
                    // starts from a settled pc.
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_req_q && imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= EXEC;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (halt) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            in_q     <= next_pc_d;
                            enable_q <= 1'b1;
                            state_q  <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    enable_q   <= 1'b0;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q    <= IDLE;
                    enable_q   <= 1'b0;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign in       = in_q;
    assign enable   = enable_q;
    assign imem_req = imem_req_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [10:0] pc;
    logic [10:0] in;
    logic        enable;
    logic        imem_req;
    logic        imem_ack;
    logic        exec_done;
    logic        branch_taken;
    logic        jump;
    logic        call;
    logic        ret;
    logic        halt;
    logic [10:0] target;
    logic [2:0]  state;
    logic        halted;
    logic        ras_err;

    int n_checks;
    int n_fail;
    int hs_timeouts;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .in           (in),
        .enable       (enable),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .halt         (halt),
        .target       (target),
        .state        (state),
        .halted       (halted),
        .ras_err      (ras_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack     = 1'b0;
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        call         = 1'b0;
        ret          = 1'b0;
        halt         = 1'b0;
    endtask

    // Returns at a falling edge just after reset release, before the first
    // rising edge.
    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        pc     = 11'd0;
        target = 11'd0;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One full instruction: fetch handshake, exec_done with the given
    // redirects, then three samples of enable starting at the exec edge.
    task automatic run_instr(input logic [10:0] pc_v, input logic br, input logic jmp,
                             input logic cl, input logic rt, input logic hl,
                             input logic [10:0] tgt,
                             output logic [10:0] in_obs, output logic [2:0] st_obs,
                             output int pulses);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) hs_timeouts++;
        imem_ack = 1'b1;
        tick();
        imem_ack     = 1'b0;
        pc           = pc_v;
        target       = tgt;
        branch_taken = br;
        jump         = jmp;
        call         = cl;
        ret          = rt;
        halt         = hl;
        exec_done    = 1'b1;
        tick();
        clear_inputs();
        in_obs = in;
        st_obs = state;
        pulses = (enable === 1'b1) ? 1 : 0;
        tick();
        if (enable === 1'b1) pulses++;
        tick();
        if (enable === 1'b1) pulses++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #3;
        n_checks++;
        if (state !== 3'd0 || in !== 11'd0 || enable !== 1'b0 || imem_req !== 1'b0 ||
            halted !== 1'b0 || ras_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d in=%0d en=%b req=%b halted=%b err=%b, want all 0",
                     state, in, enable, imem_req, halted, ras_err);
        end
        do_reset();
        n_checks++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d req=%b, want 0/0", state, imem_req);
        end
        tick();
        n_checks++;
        if (state !== 3'd1 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge: state=%0d req=%b, want 1/0", state, imem_req);
        end
        tick();
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL second_edge_req: req=%b, want 1", imem_req);
        end
    endtask

    task automatic test_increment();
        logic [10:0] io;
        logic [2:0]  so;
        int          p;
        run_instr(11'd5, 0, 0, 0, 0, 0, 11'd0, io, so, p);
        n_checks++;
        if (io !== 11'd6 || so !== 3'd3 || p != 1) begin
            n_fail++;
            $display("FAIL inc_5: in=%0d state=%0d pulses=%0d, want 6/3/1", io, so, p);
        end
        run_instr(11'd2047, 0, 0, 0, 0, 0, 11'd0, io, so, p);
        n_checks++;
        if (io !== 11'd0 || p != 1) begin
            n_fail++;
            $display("FAIL inc_wrap: in=%0d pulses=%0d, want 0/1", io, p);
        end
    endtask

    task automatic test_priority();
        logic [10:0] io;
        logic [2:0]  so;
        int          p;
        run_instr(11'd12, 1, 1, 0, 0, 0, 11'd300, io, so, p);
        n_checks++;
        if (io !== 11'd300 || p != 1) begin
            n_fail++;
            $display("FAIL br_jump: in=%0d pulses=%0d, want 300/1", io, p);
        end
        run_instr(11'd40, 1, 0, 0, 0, 0, 11'd77, io, so, p);
        n_checks++;
        if (io !== 11'd77) begin
            n_fail++;
            $display("FAIL branch: in=%0d, want 77", io);
        end
    endtask

    task automatic test_fetch_stall();
        int bad;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req !== 1'b1 || enable !== 1'b0 || state !== 3'd1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall: %0d bad cycles, want 0 (req=%b en=%b state=%0d)",
                     bad, imem_req, enable, state);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (state !== 3'd2 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ack: state=%0d req=%b, want 2/0", state, imem_req);
        end
        // Ack and redirects without exec_done must not move EXEC.
        imem_ack = 1'b1;
        jump     = 1'b1;
        target   = 11'd500;
        tick();
        clear_inputs();
        n_checks++;
        if (state !== 3'd2 || enable !== 1'b0 || in !== 11'd77) begin
            n_fail++;
            $display("FAIL exec_ignore: state=%0d en=%b in=%0d, want 2/0/77", state, enable, in);
        end
        pc        = 11'd7;
        exec_done = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (state !== 3'd3 || enable !== 1'b1 || in !== 11'd8) begin
            n_fail++;
            $display("FAIL exec_done: state=%0d en=%b in=%0d, want 3/1/8", state, enable, in);
        end
        tick();
        n_checks++;
        if (state !== 3'd1 || enable !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL write_exit: state=%0d en=%b req=%b, want 1/0/1", state, enable, imem_req);
        end
    endtask

    task automatic test_ras();
        logic [10:0] io;
        logic [2:0]  so;
        int          p;
        do_reset();
        run_instr(11'd10, 0, 0, 1, 0, 0, 11'd100, io, so, p);
        n_checks++;
        if (io !== 11'd100) begin
            n_fail++;
            $display("FAIL call: in=%0d, want 100", io);
        end
`ifdef PC_SEQUENCER_RAS_EN
        run_instr(11'd100, 0, 0, 0, 1, 0, 11'd0, io, so, p);
        n_checks++;
        if (io !== 11'd11 || ras_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ret: in=%0d err=%b, want 11/0", io, ras_err);
        end
        for (int i = 1; i <= 4; i++) run_instr(11'(i), 0, 0, 1, 0, 0, 11'd50, io, so, p);
        n_checks++;
        if (ras_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ras_four: err=%b, want 0", ras_err);
        end
        run_instr(11'd5, 0, 0, 1, 0, 0, 11'd50, io, so, p);
        n_checks++;
        if (ras_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ras_overflow: err=%b, want 1", ras_err);
        end
        // Oldest return (2) was dropped; remaining pop order is 6,5,4,3.
        for (int i = 0; i < 4; i++) begin
            run_instr(11'd50, 0, 0, 0, 1, 0, 11'd0, io, so, p);
            n_checks++;
            if (io !== 11'(6 - i)) begin
                n_fail++;
                $display("FAIL ras_pop%0d: in=%0d, want %0d", i, io, 6 - i);
            end
        end
        do_reset();
        run_instr(11'd20, 0, 0, 0, 1, 0, 11'd0, io, so, p);
        n_checks++;
        if (io !== 11'd21 || ras_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ras_underflow: in=%0d err=%b, want 21/1", io, ras_err);
        end
`else
        run_instr(11'd100, 0, 0, 0, 1, 0, 11'd0, io, so, p);
        n_checks++;
        if (io !== 11'd101) begin
            n_fail++;
            $display("FAIL ret_inc: in=%0d, want 101", io);
        end
        for (int i = 1; i <= 5; i++) run_instr(11'(i), 0, 0, 1, 0, 0, 11'd50, io, so, p);
        n_checks++;
        if (ras_err !== 1'b0 || io !== 11'd50) begin
            n_fail++;
            $display("FAIL no_ras_calls: err=%b in=%0d, want 0/50", ras_err, io);
        end
        run_instr(11'd30, 0, 0, 1, 1, 0, 11'd400, io, so, p);
        n_checks++;
        if (io !== 11'd31) begin
            n_fail++;
            $display("FAIL ret_over_call: in=%0d, want 31", io);
        end
`endif
    endtask

    task automatic test_halt();
        logic [10:0] io;
        logic [2:0]  so;
        int          p;
        int          en_hi;
        int          not_halt;
        do_reset();
        run_instr(11'd5, 0, 0, 0, 0, 0, 11'd0, io, so, p);
        run_instr(11'd40, 0, 0, 0, 1, 1, 11'd9, io, so, p);
        n_checks++;
        if (so !== 3'd4 || halted !== 1'b1 || io !== 11'd6 || p != 0) begin
            n_fail++;
            $display("FAIL halt: state=%0d halted=%b in=%0d pulses=%0d, want 4/1/6/0",
                     so, halted, io, p);
        end
        en_hi    = 0;
        not_halt = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack  = i[0];
            exec_done = ~i[0];
            jump      = 1'b1;
            tick();
            if (enable !== 1'b0) en_hi++;
            if (state !== 3'd4 || halted !== 1'b1 || imem_req !== 1'b0) not_halt++;
        end
        clear_inputs();
        n_checks++;
        if (en_hi != 0 || not_halt != 0) begin
            n_fail++;
            $display("FAIL halt_hold: enable_high=%0d not_halted=%0d, want 0/0", en_hi, not_halt);
        end
    endtask

    task automatic test_reset_in_write();
        int n;
        do_reset();
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) hs_timeouts++;
        imem_ack = 1'b1;
        tick();
        imem_ack  = 1'b0;
        pc        = 11'd3;
        exec_done = 1'b1;
        tick();
        clear_inputs();
        n_checks++;
        if (state !== 3'd3 || enable !== 1'b1 || in !== 11'd4) begin
            n_fail++;
            $display("FAIL pre_reset_write: state=%0d en=%b in=%0d, want 3/1/4", state, enable, in);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || enable !== 1'b0 || in !== 11'd0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d en=%b in=%0d req=%b, want 0/0/0/0",
                     state, enable, in, imem_req);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_handshake_bound();
        n_checks++;
        if (hs_timeouts != 0) begin
            n_fail++;
            $display("FAIL handshake_timeout: %0d timeouts, want 0", hs_timeouts);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        hs_timeouts = 0;
        pc          = 11'd0;
        target      = 11'd0;
        test_reset();
        test_increment();
        test_priority();
        test_fetch_stall();
        test_ras();
        test_halt();
        test_reset_in_write();
        test_handshake_bound();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
